// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

   localparam int unsigned MEM_BYTES_DFLT = 128;
   localparam int unsigned AW             = 16;
   localparam int unsigned DW             = 16;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic          we;
      logic          size;
      logic          sgn;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } lsu_req_t;

   // A word needs both a and a+1 inside the memory; a byte only needs a.
   function automatic logic addr_fault(input logic size, input logic [AW-1:0] addr,
                                       input int unsigned mem_bytes);
      if (size == SZ_WORD) return 32'(addr) > (mem_bytes - 32'd2);
      else                 return 32'(addr) > (mem_bytes - 32'd1);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface mem_stage_lsu_if;
   import lsu_pkg::*;

   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic          req_size;
   logic          req_signed;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;

   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_fault;

   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // Pipeline + memory side
   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   // Load/store unit side
   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault,
             mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_load_format.sv
// Turns a big-endian memory word into the load result: full word, or the
// high byte (lowest address) sign- or zero-extended.
module lsu_load_format
   import lsu_pkg::*;
(
   input  logic          size_i,
   input  logic          sgn_i,
   input  logic [DW-1:0] word_i,
   output logic [DW-1:0] data_o_c
);

   logic [7:0] byte_c;

   assign byte_c = word_i[DW-1 -: 8];

   always_comb begin
      data_o_c = word_i;
      if (size_i == SZ_BYTE) begin
         data_o_c = {{(DW-8){sgn_i & byte_c[7]}}, byte_c};
      end
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one request in flight, byte stores done as
// read-modify-write on the 16-bit big-endian data memory, range faults.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DFLT
)(
   input  logic            clk,
   input  logic            rst,
   mem_stage_lsu_if.slave  bus
);

   lsu_state_e    state_q, state_d;
   lsu_req_t      req_q, req_d;
   logic [7:0]    save_q, save_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_fault_q, rsp_fault_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [DW-1:0] load_data_c;
   logic          fault_c;

   lsu_load_format u_fmt (
      .size_i   (req_q.size),
      .sgn_i    (req_q.sgn),
      .word_i   (bus.mem_rdata),
      .data_o_c (load_data_c)
   );

   assign fault_c = addr_fault(bus.req_size, bus.req_addr, MEM_BYTES);

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;

   // State and latched request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_q       <= '0;
         save_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         save_q      <= save_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Next state; memory strobes come only from state and latched request
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      save_d        = save_q;
      rsp_fault_d   = rsp_fault_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_valid_d   = 1'b0;
      bus.req_ready = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               req_d.we    = bus.req_we;
               req_d.size  = bus.req_size;
               req_d.sgn   = bus.req_signed;
               req_d.addr  = bus.req_addr;
               req_d.wdata = bus.req_wdata;
               rsp_rdata_d = '0;
               rsp_fault_d = fault_c;
               state_d     = fault_c ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_addr = req_q.addr;
            if (!req_q.we) begin
               bus.mem_read = 1'b1;
               rsp_rdata_d  = load_data_c;
               state_d      = RESP;
            end else if (req_q.size == SZ_WORD) begin
               bus.mem_write = 1'b1;
               bus.mem_wdata = req_q.wdata;
               state_d       = RESP;
            end else begin
               // keep M[a+1] so the merged word write leaves it intact
               bus.mem_read = 1'b1;
               save_d       = bus.mem_rdata[7:0];
               state_d      = MERGE;
            end
         end
         MERGE: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = req_q.addr;
            bus.mem_wdata = DW'({req_q.wdata[7:0], save_q});
            state_d       = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rsp_valid_d = (state_d == RESP);
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: byte-array memory, transaction-level reference
// model, directed cases followed by random traffic.
module tb_mem_stage_lsu;
   import lsu_pkg::*;

   localparam int unsigned NB = MEM_BYTES_DFLT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.MEM_BYTES(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem      [0:255];
   logic [7:0] seed     [0:255];
   logic [7:0] ref_mem  [0:NB-1];
   logic       init_req = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         rd_cnt   = 0;
   int         wr_cnt   = 0;
   int         rsp_cnt  = 0;

   // Data memory: combinational read, write on the clock edge
   assign bus.mem_rdata = {mem[bus.mem_addr[7:0]], mem[8'(bus.mem_addr[7:0] + 8'd1)]};

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed[i];
      end else if (bus.mem_write) begin
         mem[bus.mem_addr[7:0]]               <= bus.mem_wdata[15:8];
         mem[8'(bus.mem_addr[7:0] + 8'd1)]    <= bus.mem_wdata[7:0];
      end
      if (bus.mem_read)  rd_cnt  <= rd_cnt + 1;
      if (bus.mem_write) wr_cnt  <= wr_cnt + 1;
      if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_load(input bit size, input bit sgn, input int a);
      int b;
      if (size) return {ref_mem[a], ref_mem[a+1]};
      b = int'(ref_mem[a]);
      if (sgn && b >= 128) return 16'(b + 32'hFF00);
      return 16'(b);
   endfunction

   // Issue one request from an idle negedge and check its response
   task automatic do_req(input string tag, input bit we, input bit size, input bit sgn,
                         input logic [15:0] addr, input logic [15:0] wdata);
      bit            exp_fault, got, fault;
      int            exp_lat, lat, rd0, wr0, waited;
      logic [15:0]   exp_data, rdata;

      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd1);

      exp_fault = size ? (32'(addr) > NB - 2) : (32'(addr) > NB - 1);
      exp_lat   = exp_fault ? 1 : ((we && !size) ? 3 : 2);
      exp_data  = (exp_fault || we) ? 16'h0000 : exp_load(size, sgn, int'(addr));

      rd0 = rd_cnt;
      wr0 = wr_cnt;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);

      got = 0; lat = 0; rdata = '0; fault = 0;
      for (int n = 1; n <= 8 && !got; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.req_valid  = 1'($urandom);
            bus.req_we     = 1'($urandom);
            bus.req_size   = 1'($urandom);
            bus.req_signed = 1'($urandom);
            bus.req_addr   = 16'($urandom);
            bus.req_wdata  = 16'($urandom);
         end
         if (bus.rsp_valid) begin
            got = 1; lat = n; rdata = bus.rsp_rdata; fault = bus.rsp_fault;
         end
      end

      if (!got) begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check_eq({tag, "_lat"},   32'(lat),   32'(exp_lat));
         check_eq({tag, "_fault"}, 32'(fault), 32'(exp_fault));
         check_eq({tag, "_rdata"}, 32'(rdata), 32'(exp_data));
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_eq({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
      check_eq({tag, "_idle"},  32'(bus.req_ready), 32'd1);
      check_eq({tag, "_nrd"}, 32'(rd_cnt - rd0), exp_fault ? 32'd0 : ((!we || !size) ? 32'd1 : 32'd0));
      check_eq({tag, "_nwr"}, 32'(wr_cnt - wr0), (exp_fault || !we) ? 32'd0 : 32'd1);

      if (!exp_fault && we) begin
         if (size) begin
            ref_mem[int'(addr)]   = wdata[15:8];
            ref_mem[int'(addr)+1] = wdata[7:0];
         end else begin
            ref_mem[int'(addr)]   = wdata[7:0];
         end
      end
   endtask

   initial begin
      int rsp0, wr0;
      int r;
      logic [15:0] a;

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 1'b0;
      bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

      for (int i = 0; i < 256; i++) seed[i] = 8'($urandom);
      seed[0] = 8'hAB; seed[1] = 8'h99; seed[6] = 8'h00; seed[7] = 8'h00;
      for (int i = 0; i < int'(NB); i++) ref_mem[i] = seed[i];
      init_req = 1'b1;
      @(posedge clk);
      #1 init_req = 1'b0;

      repeat (2) @(negedge clk);
      check_eq("rst_ready",  32'(bus.req_ready), 32'd1);
      check_eq("rst_valid",  32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rdata",  32'(bus.rsp_rdata), 32'd0);
      check_eq("rst_fault",  32'(bus.rsp_fault), 32'd0);
      check_eq("rst_memrd",  32'(bus.mem_read),  32'd0);
      check_eq("rst_memwr",  32'(bus.mem_write), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      do_req("ld_w0",    1'b0, SZ_WORD, 1'b0, 16'd0, 16'h0);
      check_eq("ld_w0_const", 32'(exp_load(1'b1, 1'b0, 0)), 32'hAB99);
      do_req("ld_b0_s",  1'b0, SZ_BYTE, 1'b1, 16'd0, 16'h0);
      do_req("ld_b0_u",  1'b0, SZ_BYTE, 1'b0, 16'd0, 16'h0);
      do_req("ld_b1_s",  1'b0, SZ_BYTE, 1'b1, 16'd1, 16'h0);
      do_req("st_b1",    1'b1, SZ_BYTE, 1'b0, 16'd1, 16'h125A);
      do_req("ld_w0b",   1'b0, SZ_WORD, 1'b0, 16'd0, 16'h0);
      do_req("ld_w2",    1'b0, SZ_WORD, 1'b0, 16'd2, 16'h0);
      do_req("st_w4",    1'b1, SZ_WORD, 1'b0, 16'd4, 16'hBEEF);
      do_req("ld_b5_u",  1'b0, SZ_BYTE, 1'b0, 16'd5, 16'h0);
      do_req("ld_w4",    1'b0, SZ_WORD, 1'b0, 16'd4, 16'h0);
      do_req("ld_w127",  1'b0, SZ_WORD, 1'b0, 16'd127, 16'h0);
      do_req("st_b128",  1'b1, SZ_BYTE, 1'b0, 16'd128, 16'h00C3);
      do_req("ld_w126",  1'b0, SZ_WORD, 1'b0, 16'd126, 16'h0);
      do_req("ld_b127",  1'b0, SZ_BYTE, 1'b1, 16'd127, 16'h0);
      do_req("st_wffff", 1'b1, SZ_WORD, 1'b0, 16'hFFFF, 16'h1234);

      // Reset while a byte store to 6 sits in MERGE
      rsp0 = rsp_cnt;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE;
      bus.req_signed = 1'b0; bus.req_addr = 16'd6; bus.req_wdata = 16'h77E1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wr0 = wr_cnt;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("mrst_ready", 32'(bus.req_ready), 32'd1);
      check_eq("mrst_memwr", 32'(bus.mem_write), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("mrst_nwr", 32'(wr_cnt - wr0), 32'd0);
      check_eq("mrst_nrsp", 32'(rsp_cnt - rsp0), 32'd0);
      check_eq("mrst_ready2", 32'(bus.req_ready), 32'd1);
      do_req("ld_w6", 1'b0, SZ_WORD, 1'b0, 16'd6, 16'h0);
      check_eq("ld_w6_const", 32'(exp_load(1'b1, 1'b0, 6)), 32'h0000);

      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 9));
         a = (r == 0) ? 16'($urandom) : 16'($urandom_range(0, NB + 1));
         do_req("rnd", 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
